clk_div_sched: RTL

Run-time controller for the team's clock-enable divider. It accepts divide-ratio and duty configuration over a valid/ready handshake, checks it, and applies it only at a period boundary so `clk_div` never shows a truncated or glitched period. It also starts and stops the divider cleanly on `en`. It sits between the register/config logic and the counter core that drives `clk_div` to downstream blocks.

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/clk_div_sched_if.sv | 26 ++
 rtl/div_core.sv | 33 +++
 rtl/clk_div_sched.sv | 125 ++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the run-time clock-enable divider controller.
// Holds the scheduler state encoding and the config validity rule.
package clk_div_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } sched_state_t;

    // Callers zero-extend to 32 bits so one function serves any CNT_W.
    function automatic logic cfg_ok(
        input logic [31:0] div,
        input logic [31:0] duty
    );
        return (div >= 32'd2) && (duty <= div);
    endfunction

endpackage

// File: rtl/clk_div_sched_if.sv
// Config handshake bundle: divide ratio and duty offered over valid/ready.
// The config source drives master, the scheduler consumes via slave.
interface clk_div_sched_if #(
    parameter int CNT_W = 8
);

    logic             valid;
    logic             ready;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] duty;

    modport master (
        output valid,
        output div,
        output duty,
        input  ready
    );

    modport slave (
        input  valid,
        input  div,
        input  duty,
        output ready
    );

endinterface

// File: rtl/div_core.sv
// Programmable period counter with a registered duty compare.
// Counter parks at zero while stopped; wrap flags the last cycle of a period.
module div_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [CNT_W-1:0] div,
    input  logic [CNT_W-1:0] duty,
    output logic             clk_div,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;

    assign wrap = run && (cnt == div - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_div <= 1'b0;
        end else begin
            clk_div <= run && (cnt < duty);
            if (!run || wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Run-time controller for the clock-enable divider: accepts and checks
// configs, applies them only on period boundaries, and starts/stops cleanly.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_DIV  = 16,
    parameter int DEF_DUTY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    clk_div_sched_if.slave   cfg,
    output logic             clk_div,
    output logic             period_end,
    output logic             cfg_err,
    output logic             busy,
    output logic [CNT_W-1:0] act_div,
    output logic [CNT_W-1:0] act_duty
);

    localparam logic [CNT_W-1:0] DIV0  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DUTY0 = CNT_W'(DEF_DUTY);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [CNT_W-1:0] sh_div;
    logic [CNT_W-1:0] sh_duty;
    logic             fire;
    logic             ok;
    logic             wrap;
    logic             load_cfg;
    logic             load_sh;
    logic             apply_sh;

    assign cfg.ready  = (state != PEND);
    assign fire       = cfg.valid && cfg.ready;
    assign ok         = cfg_ok(32'(cfg.div), 32'(cfg.duty));
    assign busy       = (state != STOP);
    assign period_end = wrap;

    always_comb begin
        state_nxt = state;
        load_cfg  = 1'b0;
        load_sh   = 1'b0;
        apply_sh  = 1'b0;
        unique case (state)
            STOP: begin
                load_cfg = fire && ok;
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Stopping at this wrap: a config arriving now lands on the
                // same boundary, so it can go straight into effect.
                if (wrap && !en) begin
                    state_nxt = STOP;
                    load_cfg  = fire && ok;
                end else if (fire && ok) begin
                    load_sh   = 1'b1;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (wrap) begin
                    apply_sh  = 1'b1;
                    state_nxt = en ? RUN : STOP;
                end
            end
            default: begin
                state_nxt = STOP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STOP;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_div  <= DIV0;
            act_duty <= DUTY0;
            sh_div   <= DIV0;
            sh_duty  <= DUTY0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= fire && !ok;
            if (load_sh) begin
                sh_div  <= cfg.div;
                sh_duty <= cfg.duty;
            end
            unique case (1'b1)
                load_cfg: begin
                    act_div  <= cfg.div;
                    act_duty <= cfg.duty;
                end
                apply_sh: begin
                    act_div  <= sh_div;
                    act_duty <= sh_duty;
                end
                default: begin
                end
            endcase
        end
    end

    div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (busy),
        .div     (act_div),
        .duty    (act_duty),
        .clk_div (clk_div),
        .wrap    (wrap)
    );

endmodule
